cc_reg_bank: RTL and testbench

// Parametrised bank of DEPTH registers, each DATA_WIDTH bits, behind an

---
 rtl/cc_reg_bank_pkg.sv | 30 +++
 rtl/cc_addr_pointer.sv | 30 +++
 rtl/cc_reg_bank.sv | 82 ++++++++
 tb/tb_cc_reg_bank.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cc_reg_bank_pkg.sv
// Shared definitions for the cc_reg_bank register bank: default widths and
// the access-type encoding derived from the host strobes.
package cc_reg_bank_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    ACC_IDLE    = 2'd0,
    ACC_WRITE   = 2'd1,
    ACC_READ    = 2'd2,
    ACC_ILLEGAL = 2'd3
  } acc_e;

  // Classify one cycle of host strobes; wr and rd together is an illegal access
  function automatic acc_e decode_access(input logic sel, input logic wr, input logic rd);
    acc_e acc;
    acc = ACC_IDLE;
    if (sel) begin
      case ({wr, rd})
        2'b10:   acc = ACC_WRITE;
        2'b01:   acc = ACC_READ;
        2'b11:   acc = ACC_ILLEGAL;
        default: acc = ACC_IDLE;
      endcase
    end
    return acc;
  endfunction

endpackage

// File: rtl/cc_addr_pointer.sv
// Address pointer for cc_reg_bank: same-cycle load override, optional
// post-access increment that wraps modulo 2**ADDR_WIDTH.
module cc_addr_pointer #(
  parameter int ADDR_WIDTH = 4,
  parameter int AUTO_INC   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  advance,
  input  logic                  addr_load,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] ea,
  output logic [ADDR_WIDTH-1:0] ptr
);

  // A load in the same cycle as an access redirects that access
  assign ea = addr_load ? addr_in : ptr;

  // Advance past the accessed word, otherwise take a pending load, otherwise hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (advance && (AUTO_INC != 0)) begin
      ptr <= ea + 1'b1;
    end else if (addr_load) begin
      ptr <= addr_in;
    end
  end

endmodule

// File: rtl/cc_reg_bank.sv
// Bank of 2**ADDR_WIDTH control registers behind an auto-incrementing pointer,
// with registered reads, an output-enable for the bus tristate and a flat
// parallel view of every register.
module cc_reg_bank
  import cc_reg_bank_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int AUTO_INC   = 1,
  localparam int DEPTH     = 1 << ADDR_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        sel,
  input  logic                        wr,
  input  logic                        rd,
  input  logic                        addr_load,
  input  logic [ADDR_WIDTH-1:0]       addr_in,
  input  logic [DATA_WIDTH-1:0]       data_in,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        data_oe,
  output logic [ADDR_WIDTH-1:0]       addr_out,
  output logic [DATA_WIDTH*DEPTH-1:0] regs_q
);

  acc_e                  acc;
  logic                  advance;
  logic [ADDR_WIDTH-1:0] ea;
  logic [DEPTH-1:0]      we;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign acc     = decode_access(sel, wr, rd);
  assign advance = (acc == ACC_WRITE) || (acc == ACC_READ);

  cc_addr_pointer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .AUTO_INC   (AUTO_INC)
  ) u_ptr (
    .clk       (clk),
    .reset_n   (reset_n),
    .advance   (advance),
    .addr_load (addr_load),
    .addr_in   (addr_in),
    .ea        (ea),
    .ptr       (addr_out)
  );

  // One-hot write-enable decode of the effective address, only on a legal write
  always_comb begin
    we = '0;
    if (acc == ACC_WRITE) begin
      we[ea] = 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    // Register i captures write data when its decoded enable is set
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        mem[i] <= '0;
      end else if (we[i]) begin
        mem[i] <= data_in;
      end
    end

    assign regs_q[i*DATA_WIDTH +: DATA_WIDTH] = mem[i];
  end

  // Registered read port; data_out holds its last word when no read occurs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
      data_oe  <= 1'b0;
    end else begin
      data_oe <= (acc == ACC_READ);
      if (acc == ACC_READ) begin
        data_out <= mem[ea];
      end
    end
  end

endmodule

// File: tb/tb_cc_reg_bank.sv
// Directed testbench for cc_reg_bank: one auto-incrementing instance and one
// static-pointer instance sharing the same host stimulus.
module tb_cc_reg_bank;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          reset_n;
  logic          sel, wr, rd, addr_load;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;

  logic [DW-1:0]       data_out0, data_out1;
  logic                data_oe0, data_oe1;
  logic [AW-1:0]       addr_out0, addr_out1;
  logic [DW*DEPTH-1:0] regs_q0, regs_q1;

  int n_vec;
  int n_bad;

  logic [DW-1:0] exp_mem [DEPTH];

  cc_reg_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AUTO_INC(1)) dut (
    .clk(clk), .reset_n(reset_n), .sel(sel), .wr(wr), .rd(rd),
    .addr_load(addr_load), .addr_in(addr_in), .data_in(data_in),
    .data_out(data_out0), .data_oe(data_oe0), .addr_out(addr_out0), .regs_q(regs_q0)
  );

  cc_reg_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AUTO_INC(0)) dut_static (
    .clk(clk), .reset_n(reset_n), .sel(sel), .wr(wr), .rd(rd),
    .addr_load(addr_load), .addr_in(addr_in), .data_in(data_in),
    .data_out(data_out1), .data_oe(data_oe1), .addr_out(addr_out1), .regs_q(regs_q1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW*DEPTH-1:0] obs, input logic [DW*DEPTH-1:0] want);
    n_vec++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [DW-1:0] reg_of(input logic [DW*DEPTH-1:0] q, input int i);
    return q[i*DW +: DW];
  endfunction

  function automatic logic [DW*DEPTH-1:0] pack_exp();
    logic [DW*DEPTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[i*DW +: DW] = exp_mem[i];
    return v;
  endfunction

  task automatic idle();
    sel = 0; wr = 0; rd = 0; addr_load = 0; addr_in = '0; data_in = '0;
  endtask

  // Apply the current inputs across one rising edge, then settle
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    idle();
    reset_n = 1'b0;
    #12;
    chk("por_regs", regs_q0, '0);
    chk("por_addr", addr_out0, '0);
    chk("por_oe", data_oe0, 1'b0);
    reset_n = 1'b1;

    // Populate state, then assert reset mid-cycle and expect immediate clear
    sel = 1; wr = 1; addr_load = 1; addr_in = 4'd3; data_in = 8'h55;
    cyc();
    wr = 0; rd = 1; addr_in = 4'd3;
    cyc();
    idle();
    chk("pre_rst_oe", data_oe0, 1'b1);
    chk("pre_rst_data", data_out0, 8'h55);
    #4;
    reset_n = 1'b0;
    #1;
    chk("rst_regs", regs_q0, '0);
    chk("rst_addr", addr_out0, '0);
    chk("rst_oe", data_oe0, 1'b0);
    chk("rst_data", data_out0, '0);
    #2;
    reset_n = 1'b1;

    // Burst write from 2
    sel = 1; wr = 1; addr_load = 1; addr_in = 4'd2; data_in = 8'hA1;
    cyc();
    addr_load = 0; data_in = 8'hA2;
    cyc();
    data_in = 8'hA3;
    cyc();
    idle();
    exp_mem[2] = 8'hA1; exp_mem[3] = 8'hA2; exp_mem[4] = 8'hA3;
    chk("burst_r2", reg_of(regs_q0, 2), 8'hA1);
    chk("burst_r3", reg_of(regs_q0, 3), 8'hA2);
    chk("burst_r4", reg_of(regs_q0, 4), 8'hA3);
    chk("burst_ptr", addr_out0, 4'd5);
    chk("burst_all", regs_q0, pack_exp());

    // Pointer wrap 15 -> 0
    sel = 1; wr = 1; addr_load = 1; addr_in = 4'd15; data_in = 8'h11;
    cyc();
    addr_load = 0; data_in = 8'h22;
    cyc();
    idle();
    exp_mem[15] = 8'h11; exp_mem[0] = 8'h22;
    chk("wrap_r15", reg_of(regs_q0, 15), 8'h11);
    chk("wrap_r0", reg_of(regs_q0, 0), 8'h22);
    chk("wrap_ptr", addr_out0, 4'd1);

    // Burst read from 2
    sel = 1; rd = 1; addr_load = 1; addr_in = 4'd2;
    cyc();
    addr_load = 0;
    chk("rd0_data", data_out0, 8'hA1);
    chk("rd0_oe", data_oe0, 1'b1);
    cyc();
    chk("rd1_data", data_out0, 8'hA2);
    chk("rd1_oe", data_oe0, 1'b1);
    cyc();
    idle();
    chk("rd2_data", data_out0, 8'hA3);
    chk("rd2_oe", data_oe0, 1'b1);
    cyc();
    chk("rd_end_oe", data_oe0, 1'b0);
    chk("rd_end_hold", data_out0, 8'hA3);
    chk("rd_end_ptr", addr_out0, 4'd5);

    // Illegal wr&rd at 7: nothing changes except the load
    sel = 1; wr = 1; rd = 1; addr_load = 1; addr_in = 4'd7; data_in = 8'h99;
    cyc();
    idle();
    chk("ill_regs", regs_q0, pack_exp());
    chk("ill_oe", data_oe0, 1'b0);
    chk("ill_ptr", addr_out0, 4'd7);

    // Deselected write is ignored
    sel = 0; wr = 1; data_in = 8'h77;
    cyc();
    idle();
    chk("nosel_r7", reg_of(regs_q0, 7), 8'h00);
    chk("nosel_regs", regs_q0, pack_exp());
    chk("nosel_ptr", addr_out0, 4'd7);

    // Deselected pointer load is honoured
    sel = 0; addr_load = 1; addr_in = 4'd9;
    cyc();
    idle();
    chk("nosel_load", addr_out0, 4'd9);

    // Read of the address written on the previous cycle
    sel = 1; wr = 1; addr_load = 1; addr_in = 4'd8; data_in = 8'h5A;
    cyc();
    wr = 0; rd = 1; addr_in = 4'd8;
    cyc();
    idle();
    exp_mem[8] = 8'h5A;
    chk("raw_data", data_out0, 8'h5A);
    chk("raw_ptr", addr_out0, 4'd9);

    // Static pointer: three writes land on the same register
    sel = 1; wr = 1; addr_load = 1; addr_in = 4'd4; data_in = 8'h31;
    cyc();
    addr_load = 0; data_in = 8'h32;
    cyc();
    data_in = 8'h33;
    cyc();
    idle();
    chk("static_r4", reg_of(regs_q1, 4), 8'h33);
    chk("static_r5", reg_of(regs_q1, 5), 8'h00);
    chk("static_ptr", addr_out1, 4'd4);
    chk("inc_r6", reg_of(regs_q0, 6), 8'h33);
    chk("inc_ptr", addr_out0, 4'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
